// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, slave states and byte-lane helpers
// for the on-chip RAM slave and its neighbours on the bus.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] mask;
  } pend_t;

  function automatic logic trans_active(
    input logic [1:0] trans
  );
    return (trans == HTRANS_NONSEQ) ||
           (trans == HTRANS_SEQ) ||
           ((trans != HTRANS_IDLE) &&
            (trans != HTRANS_BUSY));
  endfunction

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input logic [3:0]  mask
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = mask[b] ? wdata[8*b +: 8]
                            : old_word[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_lite_byte_mask.sv
// HSIZE/HADDR[1:0] to byte-lane mask, flagging misaligned
// or unsupported sizes. Also used for SDRAM DQM generation.
module ahb_lite_byte_mask
  import ahb_lite_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] mask,
  output logic       bad
);

  always_comb begin
    mask = 4'b0000;
    bad  = 1'b0;
    unique case (1'b1)
      size == HSIZE_BYTE: begin
        mask = 4'b0001 << addr;
      end
      size == HSIZE_HALF: begin
        mask = addr[1] ? 4'b1100 : 4'b0011;
        bad  = addr[0];
      end
      size == HSIZE_WORD: begin
        mask = 4'b1111;
        bad  = |addr;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_mem_ws.sv
// AHB-Lite on-chip RAM slave with wait states, byte lanes,
// pipelined write commit and read-after-write forwarding.
module ahb_lite_mem_ws
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int WORDS = 2 ** ADDR_WIDTH;

  logic [31:0] mem [WORDS];

  state_t state;
  state_t state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;

  pend_t pend;
  logic [ADDR_WIDTH-1:0] pend_idx;

  logic [3:0] mask;
  logic       bad;
  logic       accept;
  logic       range_err;
  logic       err;
  logic       commit;
  logic       fwd;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] commit_word;
  logic [31:0] rd_word;
  logic        unused_burst;

  ahb_lite_byte_mask u_mask (
    .size (HSIZE),
    .addr (HADDR[1:0]),
    .mask (mask),
    .bad  (bad)
  );

  // Bursts are treated as independent singles.
  assign unused_burst = ^HBURST;

  assign accept = HREADY && HSEL &&
                  trans_active(HTRANS);
  assign range_err = {2'b00, HADDR[31:2]} >=
                     32'(DEPTH);
  assign err = range_err || bad;
  assign idx = HADDR[ADDR_WIDTH+1:2];

  // A pending write lands on the edge that ends its data phase.
  assign commit = pend.valid && HREADY;
  assign commit_word = merge_bytes(mem[pend_idx],
                                   HWDATA, pend.mask);
  assign fwd = commit && (pend_idx == idx);
  assign rd_word = fwd ? commit_word : mem[idx];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE, S_ERR2: begin
        state_nx = S_IDLE;
        if (accept) begin
          if (err) begin
            state_nx = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nx = S_WAIT;
            cnt_nx   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_ERR1: begin
        state_nx = S_ERR2;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      HREADY   <= 1'b1;
      HRESP    <= HRESP_OKAY;
      HRDATA   <= 32'h0;
      pend     <= '0;
      pend_idx <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      HREADY <= (state_nx != S_WAIT) &&
                (state_nx != S_ERR1);
      HRESP  <= ((state_nx == S_ERR1) ||
                 (state_nx == S_ERR2)) ?
                HRESP_ERROR : HRESP_OKAY;
      if (accept && !err && !HWRITE) begin
        HRDATA <= rd_word;
      end
      if (accept && !err && HWRITE) begin
        pend.valid <= 1'b1;
        pend.mask  <= mask;
        pend_idx   <= idx;
      end else if (commit) begin
        pend.valid <= 1'b0;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      mem[pend_idx] <= commit_word;
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_ws.sv
// Bench for ahb_lite_mem_ws: three instances (0/2/3 waits)
// on a shared bus, scoreboarded against a bench memory model.
module tb_ahb_lite_mem_ws;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [2:0]  hburst = '0;
  logic [2:0]  hsize = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic        bus_sel = 1'b0;
  logic [1:0]  cur = 2'd0;

  logic [2:0]  hsel_v;
  logic [2:0]  ready_v;
  logic [2:0]  resp_v;
  logic [31:0] rdata_v [3];
  logic        ready;
  logic        resp;
  logic [31:0] rdata;

  assign hsel_v[0] = bus_sel && (cur == 2'd0);
  assign hsel_v[1] = bus_sel && (cur == 2'd1);
  assign hsel_v[2] = bus_sel && (cur == 2'd2);
  assign ready = (cur == 2'd0) ? ready_v[0] :
                 (cur == 2'd1) ? ready_v[1] : ready_v[2];
  assign resp  = (cur == 2'd0) ? resp_v[0] :
                 (cur == 2'd1) ? resp_v[1] : resp_v[2];
  assign rdata = (cur == 2'd0) ? rdata_v[0] :
                 (cur == 2'd1) ? rdata_v[1] : rdata_v[2];

  ahb_lite_mem_ws #(
    .ADDR_WIDTH(10), .DEPTH(1024), .WAIT_STATES(0)
  ) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr),
    .HBURST(hburst), .HSEL(hsel_v[0]), .HSIZE(hsize),
    .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite),
    .HRDATA(rdata_v[0]), .HREADY(ready_v[0]),
    .HRESP(resp_v[0])
  );

  ahb_lite_mem_ws #(
    .ADDR_WIDTH(10), .DEPTH(1024), .WAIT_STATES(2)
  ) u_ws2 (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr),
    .HBURST(hburst), .HSEL(hsel_v[1]), .HSIZE(hsize),
    .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite),
    .HRDATA(rdata_v[1]), .HREADY(ready_v[1]),
    .HRESP(resp_v[1])
  );

  ahb_lite_mem_ws #(
    .ADDR_WIDTH(10), .DEPTH(1024), .WAIT_STATES(3)
  ) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr),
    .HBURST(hburst), .HSEL(hsel_v[2]), .HSIZE(hsize),
    .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite),
    .HRDATA(rdata_v[2]), .HREADY(ready_v[2]),
    .HRESP(resp_v[2])
  );

  typedef struct {
    bit          rd;
    bit          err;
    int          waits;
    logic [31:0] data;
    string       name;
  } txn_t;

  int ws_of [3] = '{0, 2, 3};
  logic [31:0] mdl [3][1024];
  txn_t sb[$];
  int errors = 0;
  int checks = 0;

  // One address phase; completes the outstanding data phase.
  task automatic phase(input string nm,
                       input logic [1:0] tr,
                       input logic wr,
                       input logic [31:0] a,
                       input logic [2:0] sz,
                       input logic [31:0] wd);
    txn_t t;
    txn_t n;
    int w;
    bit done;
    bit e;
    int off;
    int nb;
    haddr = a; htrans = tr; hwrite = wr;
    hsize = sz; bus_sel = 1'b1;
    w = 0; done = 0;
    for (int k = 0; k < 32 && !done; k++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        t = sb[0];
        checks++;
        if (resp !== t.err) begin
          errors++;
          $display("FAIL %s hresp=%b want %b",
                   t.name, resp, t.err);
        end
        if (t.rd && !t.err) begin
          checks++;
          if (rdata !== t.data) begin
            errors++;
            $display("FAIL %s hrdata=%h want %h",
                     t.name, rdata, t.data);
          end
        end
      end
      if (ready === 1'b1) done = 1;
      else w++;
    end
    if (!done) begin
      errors++;
      $display("FAIL %s hready timeout got=0 want=1", nm);
    end
    if (sb.size() != 0) begin
      t = sb.pop_front();
      checks++;
      if (w != t.waits) begin
        errors++;
        $display("FAIL %s waits=%0d want %0d",
                 t.name, w, t.waits);
      end
    end
    @(posedge clk);
    #1;
    hwdata = wd;
    n.name = nm; n.rd = 0; n.err = 0;
    n.waits = 0; n.data = '0;
    if (tr[1]) begin
      e = (a >= 32'h1000) || (sz > 3'd2);
      if (!e && sz == 3'd1 && a[0]) e = 1;
      if (!e && sz == 3'd2 && a[1:0] != 2'b00) e = 1;
      n.err = e;
      n.waits = e ? 1 : ws_of[cur];
      if (!e) begin
        off = int'(a[1:0]);
        nb = 1 << sz;
        if (wr) begin
          for (int b = off; b < off + nb; b++)
            mdl[cur][a[11:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
          n.rd = 1;
          n.data = mdl[cur][a[11:2]];
        end
      end
    end
    sb.push_back(n);
  endtask

  task automatic idle(input string nm);
    phase(nm, 2'd0, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (ready_v[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_hready[%0d] got=%b want=1",
                 k, ready_v[k]);
      end
      if (resp_v[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hresp[%0d] got=%b want=0",
                 k, resp_v[k]);
      end
      if (rdata_v[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_hrdata[%0d] got=%h want=0",
                 k, rdata_v[k]);
      end
    end
  endtask

  task automatic test_fwd();
    cur = 2'd0;
    phase("fwd_wr", 2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    phase("fwd_rd", 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
    idle("fwd_idle");
  endtask

  task automatic test_byte_half();
    phase("byte_wr", 2'd2, 1'b1, 32'h13, 3'd0, 32'hAA000000);
    phase("byte_rd", 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
    phase("half_wr", 2'd2, 1'b1, 32'h10, 3'd1, 32'h00001234);
    phase("half_rd", 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
    phase("half_hi", 2'd3, 1'b1, 32'h16, 3'd1, 32'h5566FFFF);
    phase("half_hrd", 2'd2, 1'b0, 32'h14, 3'd2, 32'h0);
    idle("bh_idle");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      phase("b2b_wr", 2'd3, 1'b1, 32'h100 + 32'(4*i),
            3'd2, d);
    end
    for (int i = 0; i < 4; i++)
      phase("b2b_rd", 2'd3, 1'b0, 32'h100 + 32'(4*i),
            3'd2, 32'h0);
    idle("b2b_idle");
  endtask

  task automatic test_range_err();
    phase("rng_w0", 2'd2, 1'b1, 32'h0, 3'd2, 32'h01234567);
    phase("rng_err", 2'd2, 1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF);
    phase("rng_rd0", 2'd2, 1'b0, 32'h0, 3'd2, 32'h0);
    phase("rng_top", 2'd2, 1'b0, 32'hFFC, 3'd2, 32'h0);
    idle("rng_idle");
  endtask

  task automatic test_align_err();
    phase("al_half", 2'd2, 1'b1, 32'h1, 3'd1, 32'hFFFFFFFF);
    phase("al_size", 2'd2, 1'b1, 32'h0, 3'd3, 32'hFFFFFFFF);
    phase("al_word", 2'd2, 1'b0, 32'h2, 3'd2, 32'h0);
    phase("al_idle", 2'd0, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF);
    phase("al_busy", 2'd1, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF);
    phase("al_rd0", 2'd2, 1'b0, 32'h0, 3'd2, 32'h0);
    idle("al_end");
  endtask

  task automatic test_waits();
    cur = 2'd1;
    phase("ws_wr", 2'd2, 1'b1, 32'h20, 3'd2, 32'h5A5A0F0F);
    phase("ws_rd", 2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
    phase("ws_rd2", 2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
    phase("ws_err", 2'd2, 1'b0, 32'h2000, 3'd2, 32'h0);
    phase("ws_rd3", 2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
    idle("ws_idle");
  endtask

  task automatic test_reset_mid_wait();
    cur = 2'd2;
    phase("rmw_wr", 2'd2, 1'b1, 32'h40, 3'd2, 32'h11111111);
    phase("rmw_rd", 2'd2, 1'b0, 32'h40, 3'd2, 32'h0);
    idle("rmw_idle");
    idle("rmw_idle2");
    sb.delete();
    haddr = 32'h40; htrans = 2'd2; hwrite = 1'b1;
    hsize = 3'd2;
    @(posedge clk);
    #1;
    hwdata = 32'h22222222;
    htrans = 2'd0;
    @(posedge clk);
    #1;
    checks++;
    if (ready_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL rmw_in_wait hready=%b want 0",
               ready_v[2]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (ready_v[2] !== 1'b1) begin
      errors++;
      $display("FAIL rmw_hready got=%b want=1", ready_v[2]);
    end
    if (resp_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL rmw_hresp got=%b want=0", resp_v[2]);
    end
    if (rdata_v[2] !== 32'h0) begin
      errors++;
      $display("FAIL rmw_hrdata got=%h want=0", rdata_v[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    phase("rmw_post", 2'd2, 1'b0, 32'h40, 3'd2, 32'h0);
    idle("rmw_end");
    idle("rmw_end2");
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_fwd();
    test_byte_half();
    test_back_to_back();
    test_range_err();
    test_align_err();
    test_waits();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
